dc_port_arbiter: RTL

- Shares the single data-cache request/response port between the CPU load/store unit (LSU) and the BFS traversal engine.
- Arbitrates requests round-robin and records the owner of every accepted request in an in-order owner FIFO.
- Steers each multi-beat cache response back to the owning requester.
- Generates the BFS engine's "no responses pending" indication.
- Sits between the LSU/BFS engine and the dcache.

---
 rtl/dc_arb_pkg.sv | 16 +
 rtl/dc_port_arbiter_if.sv | 56 +++++
 rtl/dc_arb_owner_fifo.sv | 58 +++++
 rtl/dc_port_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/dc_arb_pkg.sv
// Shared constants for the dcache port arbiter slice.
// Owner encoding and default response geometry.
package dc_arb_pkg;

   localparam logic OWNER_LSU = 1'b0;
   localparam logic OWNER_BFS = 1'b1;

   localparam int DC_RESP_BEATS = 4;
   localparam int DC_ARB_DEPTH  = 4;

   // Counter width that stays legal for a size of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dc_port_arbiter_if.sv
// Bundle of LSU, BFS and dcache signals around the arbiter.
// slave = arbiter view, master = surrounding logic view.
interface dc_port_arbiter_if;

   logic        lsu_req;
   logic [31:0] lsu_addr;
   logic        arb_lsu_ready;
   logic        arb_lsu_valid;

   logic        bfs_req;
   logic [31:0] bfs_addr;
   logic        arb_bfs_ready;
   logic        arb_bfs_valid;
   logic        arb_bfs_rbuf_empty;

   logic        arb_dc_req;
   logic [31:0] arb_dc_addr;
   logic        dc_ready;
   logic        dc_valid;
   logic [63:0] dc_rdata;
   logic [63:0] arb_rdata;

   logic        arb_err;
   logic [31:0] arb_perf_lsu_grants;
   logic [31:0] arb_perf_bfs_grants;
   logic [31:0] arb_perf_conflicts;

   modport slave (
      input  lsu_req, lsu_addr,
      input  bfs_req, bfs_addr,
      input  dc_ready, dc_valid, dc_rdata,
      output arb_lsu_ready, arb_lsu_valid,
      output arb_bfs_ready, arb_bfs_valid,
      output arb_bfs_rbuf_empty,
      output arb_dc_req, arb_dc_addr, arb_rdata,
      output arb_err,
      output arb_perf_lsu_grants,
      output arb_perf_bfs_grants,
      output arb_perf_conflicts
   );

   modport master (
      output lsu_req, lsu_addr,
      output bfs_req, bfs_addr,
      output dc_ready, dc_valid, dc_rdata,
      input  arb_lsu_ready, arb_lsu_valid,
      input  arb_bfs_ready, arb_bfs_valid,
      input  arb_bfs_rbuf_empty,
      input  arb_dc_req, arb_dc_addr, arb_rdata,
      input  arb_err,
      input  arb_perf_lsu_grants,
      input  arb_perf_bfs_grants,
      input  arb_perf_conflicts
   );

endinterface

// File: rtl/dc_arb_owner_fifo.sv
// In-order FIFO of request owners (one bit per outstanding request).
// Also tracks how many BFS entries are queued.
module dc_arb_owner_fifo
   import dc_arb_pkg::*;
#(
   parameter int DEPTH = DC_ARB_DEPTH,
   localparam int AW = cnt_w(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          push_owner,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic          head,
   output logic [CW-1:0] bfs_count
);

   logic          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          bfs_push;
   logic          bfs_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign head     = mem[rd_ptr];
   assign bfs_push = push & (push_owner == OWNER_BFS);
   assign bfs_pop  = pop & (head == OWNER_BFS);

   // Storage write; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_owner;
   end

   // Pointers, occupancy and BFS entry count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         bfs_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count     <= count + CW'(push) - CW'(pop);
         bfs_count <= bfs_count + CW'(bfs_push)
                      - CW'(bfs_pop);
      end
   end

endmodule

// File: rtl/dc_port_arbiter.sv
// Round-robin share of the dcache port between LSU and BFS engine.
// Optional perf counters: define DC_PORT_ARB_PERF_EN.
module dc_port_arbiter
   import dc_arb_pkg::*;
#(
   parameter int BEATS = DC_RESP_BEATS,
   parameter int DEPTH = DC_ARB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   dc_port_arbiter_if.slave  bus
);

   localparam int BW = cnt_w(BEATS);
   localparam int CW = cnt_w(DEPTH) + 1;

   logic          prio;
   logic          err_q;
   logic [BW-1:0] beat;
   logic          avail;
   logic          lsu_fire;
   logic          bfs_fire;
   logic          fire;
   logic          steer;
   logic          last;
   logic          pop;
   logic          full;
   logic          empty;
   logic          head;
   logic [CW-1:0] bfs_count;

   assign avail = ~rst & bus.dc_ready & ~full;

   // Loser of the last conflict wins the next; the LSU term keeps
   // bfs_req out of the BFS ready path.
   assign bus.arb_bfs_ready = avail & (prio | ~bus.lsu_req);
   assign bus.arb_lsu_ready = avail & (~prio | ~bus.bfs_req);

   assign lsu_fire = bus.lsu_req & bus.arb_lsu_ready;
   assign bfs_fire = bus.bfs_req & bus.arb_bfs_ready;
   assign fire     = lsu_fire | bfs_fire;

   assign bus.arb_dc_req  = fire;
   assign bus.arb_dc_addr = bfs_fire ? bus.bfs_addr
                                     : bus.lsu_addr;

   assign steer = ~rst & bus.dc_valid & ~empty;
   assign last  = (beat == BW'(BEATS - 1));
   assign pop   = steer & last;

   assign bus.arb_lsu_valid = steer & (head == OWNER_LSU);
   assign bus.arb_bfs_valid = steer & (head == OWNER_BFS);
   assign bus.arb_rdata     = bus.dc_rdata;

   assign bus.arb_bfs_rbuf_empty = (bfs_count == '0);
   assign bus.arb_err            = err_q;

   dc_arb_owner_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fire),
      .push_owner (bfs_fire),
      .pop        (pop),
      .full       (full),
      .empty      (empty),
      .head       (head),
      .bfs_count  (bfs_count)
   );

   // Priority flip on grant, beat count, sticky orphan-beat flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio  <= 1'b0;
         beat  <= '0;
         err_q <= 1'b0;
      end else begin
         if (fire)
            prio <= ~bfs_fire;
         if (steer)
            beat <= last ? '0 : beat + 1'b1;
         if (bus.dc_valid & empty)
            err_q <= 1'b1;
      end
   end

`ifdef DC_PORT_ARB_PERF_EN
   logic [31:0] perf_lsu;
   logic [31:0] perf_bfs;
   logic [31:0] perf_cnf;

   // Wrapping grant and conflict counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lsu <= '0;
         perf_bfs <= '0;
         perf_cnf <= '0;
      end else begin
         if (lsu_fire)
            perf_lsu <= perf_lsu + 1'b1;
         if (bfs_fire)
            perf_bfs <= perf_bfs + 1'b1;
         if (bus.lsu_req & bus.bfs_req & avail)
            perf_cnf <= perf_cnf + 1'b1;
      end
   end

   assign bus.arb_perf_lsu_grants = perf_lsu;
   assign bus.arb_perf_bfs_grants = perf_bfs;
   assign bus.arb_perf_conflicts  = perf_cnf;
`else
   assign bus.arb_perf_lsu_grants = '0;
   assign bus.arb_perf_bfs_grants = '0;
   assign bus.arb_perf_conflicts  = '0;
`endif

endmodule
